// File: rtl/cpl_op_mux_rr_pkg.sv
// cpl_op_mux_pkg: shared widths and the request record for the completion-request mux.
//   PORTS / CL_PORTS : number of request ports and the width of a port index.
//   SEL, QIDX        : completion-target select and queue-index widths.
//   STAG, MTAG       : per-port input tag width and output tag width (port index + input tag).
//   CPL_BITS         : completion record width in bits (32 bytes).
//   req_t            : one completion request as it travels through the skid buffer.
package cpl_op_mux_pkg;

    localparam int PORTS    = 2;
    localparam int CL_PORTS = 1;
    localparam int SEL      = 1;
    localparam int QIDX     = 13;
    localparam int STAG     = 5;
    localparam int MTAG     = STAG + CL_PORTS;
    localparam int CPL_BITS = 256;

    typedef struct packed {
        logic [SEL-1:0]      sel;
        logic [QIDX-1:0]     queue;
        logic [MTAG-1:0]     tag;
        logic [CPL_BITS-1:0] data;
    } req_t;

endpackage

// File: rtl/cpl_op_mux_rr_arbiter.sv
// rr_arbiter: registered, blocking round-robin arbiter.
//   clk, rst     : clock, synchronous active-high reset.
//   request      : one bit per port, port is asking for the grant.
//   acknowledge  : one bit per port, granted port completed a transfer this cycle.
//   grant        : registered one-hot grant.
//   grant_valid  : registered, a grant is currently held.
//   grant_enc    : registered encoded index of the granted port.
// Arbitration picks the first requester above the last granted index, wrapping to
// the lowest requester. A grant is held until acknowledged; on the acknowledge cycle
// a new winner is chosen so back-to-back transfers run at one per cycle.
module rr_arbiter
    import cpl_op_mux_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PORTS-1:0]    request,
    input  logic [PORTS-1:0]    acknowledge,
    output logic [PORTS-1:0]    grant,
    output logic                grant_valid,
    output logic [CL_PORTS-1:0] grant_enc
);

    logic [CL_PORTS-1:0] last_grant;
    logic                pick_valid;
    logic [CL_PORTS-1:0] pick_enc;
    logic                hold;

    always_comb begin
        pick_valid = 1'b0;
        pick_enc   = '0;
        // Descending loops: the last hit is the lowest index. The second loop only
        // considers ports above the last grant and overrides the wrap-around pick.
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (request[i]) begin
                pick_valid = 1'b1;
                pick_enc   = CL_PORTS'(i);
            end
        end
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (request[i] && (i > int'(last_grant))) begin
                pick_enc = CL_PORTS'(i);
            end
        end
    end

    // A granted port whose valid has dropped is no longer waiting for anything
    // (a legal source never withdraws an offered request), so releasing it keeps
    // an idle port from starving the others after its final transfer.
    assign hold = grant_valid && request[grant_enc] && !acknowledge[grant_enc];

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_enc   <= '0;
            last_grant  <= CL_PORTS'(PORTS - 1);
        end else if (!hold) begin
            grant_valid <= pick_valid;
            grant_enc   <= pick_enc;
            grant       <= pick_valid ? (PORTS'(1) << pick_enc) : '0;
            if (pick_valid) begin
                last_grant <= pick_enc;
            end
        end
    end

endmodule

// File: rtl/cpl_op_mux_rr.sv
// cpl_op_mux_rr: round-robin completion-request multiplexer.
//   clk, rst                 : clock, synchronous active-high reset.
//   s_axis_req_*             : PORTS packed request streams (sel/queue/tag/data/valid/ready).
//   m_axis_req_*             : single merged request stream; tag = {port index, input tag}.
//   s_axis_req_status_*      : status returned by the completion writer (no backpressure).
//   m_axis_req_status_*      : status routed back to the port named in the tag MSBs;
//                              tag/full/error are replicated, valid is one-hot.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, is held with stable fields until that edge.
module cpl_op_mux_rr
    import cpl_op_mux_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    output logic [SEL-1:0]            m_axis_req_sel,
    output logic [QIDX-1:0]           m_axis_req_queue,
    output logic [MTAG-1:0]           m_axis_req_tag,
    output logic [CPL_BITS-1:0]       m_axis_req_data,
    output logic                      m_axis_req_valid,
    input  logic                      m_axis_req_ready,
    input  logic [MTAG-1:0]           s_axis_req_status_tag,
    input  logic                      s_axis_req_status_full,
    input  logic                      s_axis_req_status_error,
    input  logic                      s_axis_req_status_valid,
    input  logic [PORTS*SEL-1:0]      s_axis_req_sel,
    input  logic [PORTS*QIDX-1:0]     s_axis_req_queue,
    input  logic [PORTS*STAG-1:0]     s_axis_req_tag,
    input  logic [PORTS*CPL_BITS-1:0] s_axis_req_data,
    input  logic [PORTS-1:0]          s_axis_req_valid,
    output logic [PORTS-1:0]          s_axis_req_ready,
    output logic [PORTS*STAG-1:0]     m_axis_req_status_tag,
    output logic [PORTS-1:0]          m_axis_req_status_full,
    output logic [PORTS-1:0]          m_axis_req_status_error,
    output logic [PORTS-1:0]          m_axis_req_status_valid
);

    logic [PORTS-1:0]    grant;
    logic                grant_valid;
    logic [CL_PORTS-1:0] grant_enc;
    logic [PORTS-1:0]    acknowledge;

    req_t in_req [PORTS];
    req_t sel_req;
    req_t main_req;
    req_t temp_req;
    logic main_valid;
    logic temp_valid;
    logic out_ready;
    logic out_ready_early;
    logic valid_int;

    logic [STAG-1:0] status_tag;
    logic            status_full;
    logic            status_error;
    logic [PORTS-1:0] status_valid;

    rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .request     (s_axis_req_valid),
        .acknowledge (acknowledge),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_enc   (grant_enc)
    );

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            in_req[p].sel   = s_axis_req_sel[p*SEL +: SEL];
            in_req[p].queue = s_axis_req_queue[p*QIDX +: QIDX];
            in_req[p].tag   = {CL_PORTS'(p), s_axis_req_tag[p*STAG +: STAG]};
            in_req[p].data  = s_axis_req_data[p*CPL_BITS +: CPL_BITS];
        end
    end

    assign sel_req          = in_req[grant_enc];
    assign s_axis_req_ready = (grant_valid && out_ready) ? grant : '0;
    assign acknowledge      = grant & s_axis_req_valid & s_axis_req_ready;
    assign valid_int        = grant_valid && s_axis_req_valid[grant_enc] && out_ready;

    // Ready is registered, so it is only offered when the skid buffer could still
    // absorb one more word even if the downstream stalls on the next edge.
    assign out_ready_early = m_axis_req_ready ||
                             (!temp_valid && (!main_valid || !valid_int));

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            temp_valid <= 1'b0;
            out_ready  <= 1'b0;
        end else begin
            out_ready <= out_ready_early;
            if (out_ready) begin
                if (m_axis_req_ready || !main_valid) begin
                    main_valid <= valid_int;
                    main_req   <= sel_req;
                end else begin
                    temp_valid <= valid_int;
                    temp_req   <= sel_req;
                end
            end else if (m_axis_req_ready) begin
                main_valid <= temp_valid;
                main_req   <= temp_req;
                temp_valid <= 1'b0;
            end
        end
    end

    assign m_axis_req_sel   = main_req.sel;
    assign m_axis_req_queue = main_req.queue;
    assign m_axis_req_tag   = main_req.tag;
    assign m_axis_req_data  = main_req.data;
    assign m_axis_req_valid = main_valid;

    // Status return: the port index rides in the tag MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_valid <= '0;
        end else begin
            status_valid <= s_axis_req_status_valid ?
                            (PORTS'(1) << s_axis_req_status_tag[MTAG-1 -: CL_PORTS]) : '0;
        end
    end

    always_ff @(posedge clk) begin
        status_tag   <= s_axis_req_status_tag[STAG-1:0];
        status_full  <= s_axis_req_status_full;
        status_error <= s_axis_req_status_error;
    end

    assign m_axis_req_status_tag   = {PORTS{status_tag}};
    assign m_axis_req_status_full  = {PORTS{status_full}};
    assign m_axis_req_status_error = {PORTS{status_error}};
    assign m_axis_req_status_valid = status_valid;

endmodule

// File: tb/tb_cpl_op_mux_rr.sv
// tb_cpl_op_mux_rr: directed bench for cpl_op_mux_rr. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, so every check sees the
// registers as updated by the edge just taken.
module tb_cpl_op_mux_rr;

    logic          clk;
    logic          rst;
    logic [0:0]    m_sel;
    logic [12:0]   m_queue;
    logic [5:0]    m_tag;
    logic [255:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [5:0]    st_tag;
    logic          st_full;
    logic          st_error;
    logic          st_valid;
    logic [1:0]    s_sel;
    logic [25:0]   s_queue;
    logic [9:0]    s_tag;
    logic [511:0]  s_data;
    logic [1:0]    s_valid;
    logic [1:0]    s_ready;
    logic [9:0]    ms_tag;
    logic [1:0]    ms_full;
    logic [1:0]    ms_error;
    logic [1:0]    ms_valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] D0 = {8{32'hA5A5_A5A5}};
    localparam logic [255:0] D1 = {8{32'h5A5A_5A5A}};

    cpl_op_mux_rr dut (
        .clk                     (clk),
        .rst                     (rst),
        .m_axis_req_sel          (m_sel),
        .m_axis_req_queue        (m_queue),
        .m_axis_req_tag          (m_tag),
        .m_axis_req_data         (m_data),
        .m_axis_req_valid        (m_valid),
        .m_axis_req_ready        (m_ready),
        .s_axis_req_status_tag   (st_tag),
        .s_axis_req_status_full  (st_full),
        .s_axis_req_status_error (st_error),
        .s_axis_req_status_valid (st_valid),
        .s_axis_req_sel          (s_sel),
        .s_axis_req_queue        (s_queue),
        .s_axis_req_tag          (s_tag),
        .s_axis_req_data         (s_data),
        .s_axis_req_valid        (s_valid),
        .s_axis_req_ready        (s_ready),
        .m_axis_req_status_tag   (ms_tag),
        .m_axis_req_status_full  (ms_full),
        .m_axis_req_status_error (ms_error),
        .m_axis_req_status_valid (ms_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic v, input logic sl,
                              input logic [12:0] q, input logic [4:0] t, input logic [255:0] d);
        s_valid[p]           = v;
        s_sel[p]             = sl;
        s_queue[p*13 +: 13]  = q;
        s_tag[p*5 +: 5]      = t;
        s_data[p*256 +: 256] = d;
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        st_tag = '0; st_full = 1'b0; st_error = 1'b0; st_valid = 1'b0;
        s_sel = '0; s_queue = '0; s_tag = '0; s_data = '0; s_valid = '0;
        tick(); tick(); tick();
        check("rst_m_valid",  256'(m_valid),  256'(0));
        check("rst_st_valid", 256'(ms_valid), 256'(0));
        check("rst_s_ready",  256'(s_ready),  256'(0));
        rst = 1'b0;

        // Single request from port 0.
        drive_port(0, 1'b1, 1'b1, 13'h005, 5'h03, D0);
        tick();
        check("p0_s_ready", 256'(s_ready), 256'(2'b01));
        check("p0_no_out",  256'(m_valid), 256'(0));
        tick();
        s_valid[0] = 1'b0;
        check("p0_m_valid", 256'(m_valid), 256'(1));
        check("p0_m_tag",   256'(m_tag),   256'(6'h03));
        check("p0_m_queue", 256'(m_queue), 256'(13'h005));
        check("p0_m_data",  m_data,        D0);
        check("p0_m_sel",   256'(m_sel),   256'(1));
        tick();
        check("p0_drain", 256'(m_valid), 256'(0));

        // Both ports streaming: last grant was 0, so port 1 goes first.
        drive_port(0, 1'b1, 1'b1, 13'h00A, 5'h0A, D0);
        drive_port(1, 1'b1, 1'b0, 13'h015, 5'h15, D1);
        tick();
        check("alt_first_grant", 256'(s_ready), 256'(2'b10));
        check("alt_no_out",      256'(m_valid), 256'(0));
        tick();
        check("alt0_valid", 256'(m_valid), 256'(1));
        check("alt0_tag",   256'(m_tag),   256'(6'h35));
        check("alt0_queue", 256'(m_queue), 256'(13'h015));
        check("alt0_data",  m_data,        D1);
        tick();
        check("alt1_valid", 256'(m_valid), 256'(1));
        check("alt1_tag",   256'(m_tag),   256'(6'h0A));
        check("alt1_sel",   256'(m_sel),   256'(1));
        check("alt1_data",  m_data,        D0);
        tick();
        check("alt2_tag", 256'(m_tag), 256'(6'h35));
        tick();
        check("alt3_tag", 256'(m_tag), 256'(6'h0A));
        s_valid = 2'b00;
        tick();
        check("alt_drain", 256'(m_valid), 256'(0));

        // Backpressure on port 1: A, B fill the skid buffer, C waits.
        m_ready = 1'b0;
        drive_port(1, 1'b1, 1'b0, 13'h101, 5'h1F, D1);
        tick();
        check("bp_grant", 256'(s_ready), 256'(2'b10));
        tick();
        check("bp_a_valid", 256'(m_valid), 256'(1));
        check("bp_a_tag",   256'(m_tag),   256'(6'h3F));
        check("bp_ready1",  256'(s_ready), 256'(2'b10));
        s_queue[13 +: 13] = 13'h102;
        tick();
        check("bp_hold_q",  256'(m_queue), 256'(13'h101));
        check("bp_ready0",  256'(s_ready), 256'(2'b00));
        s_queue[13 +: 13] = 13'h103;
        tick();
        check("bp_stall2_q",     256'(m_queue), 256'(13'h101));
        check("bp_stall2_ready", 256'(s_ready), 256'(2'b00));
        tick();
        check("bp_stall3_valid", 256'(m_valid), 256'(1));
        check("bp_stall3_tag",   256'(m_tag),   256'(6'h3F));
        tick();
        check("bp_stall4_q", 256'(m_queue), 256'(13'h101));
        m_ready = 1'b1;
        tick();
        check("bp_b_q",     256'(m_queue), 256'(13'h102));
        check("bp_b_valid", 256'(m_valid), 256'(1));
        check("bp_b_ready", 256'(s_ready), 256'(2'b10));
        tick();
        check("bp_c_q", 256'(m_queue), 256'(13'h103));
        s_valid[1] = 1'b0;
        tick();
        check("bp_drain", 256'(m_valid), 256'(0));

        // Status routing.
        st_tag = 6'h25; st_full = 1'b1; st_error = 1'b0; st_valid = 1'b1;
        tick();
        check("st1_valid", 256'(ms_valid), 256'(2'b10));
        check("st1_tag1",  256'(ms_tag[9:5]), 256'(5'h05));
        check("st1_tag0",  256'(ms_tag[4:0]), 256'(5'h05));
        check("st1_full",  256'(ms_full),  256'(2'b11));
        check("st1_error", 256'(ms_error), 256'(2'b00));
        st_tag = 6'h0A; st_full = 1'b0; st_error = 1'b1;
        tick();
        check("st2_valid", 256'(ms_valid), 256'(2'b01));
        check("st2_tag0",  256'(ms_tag[4:0]), 256'(5'h0A));
        check("st2_error", 256'(ms_error), 256'(2'b11));
        check("st2_full",  256'(ms_full),  256'(2'b00));
        st_valid = 1'b0;
        tick();
        check("st3_idle", 256'(ms_valid), 256'(2'b00));

        // Reset with both skid registers occupied.
        m_ready = 1'b0;
        drive_port(0, 1'b1, 1'b0, 13'h201, 5'h01, D0);
        tick();
        tick();
        s_queue[0 +: 13] = 13'h202;
        tick();
        check("mr_full_valid", 256'(m_valid), 256'(1));
        check("mr_full_q",     256'(m_queue), 256'(13'h201));
        check("mr_full_ready", 256'(s_ready), 256'(2'b00));
        rst = 1'b1;
        drive_port(1, 1'b1, 1'b0, 13'h302, 5'h06, D1);
        st_tag = 6'h25; st_valid = 1'b1;
        tick();
        check("mr_m_valid",  256'(m_valid),  256'(0));
        check("mr_st_valid", 256'(ms_valid), 256'(0));
        check("mr_s_ready",  256'(s_ready),  256'(0));
        rst = 1'b0; m_ready = 1'b1; st_valid = 1'b0;
        drive_port(0, 1'b1, 1'b0, 13'h301, 5'h04, D0);
        tick();
        check("mr_first_grant", 256'(s_ready), 256'(2'b01));
        check("mr_no_stale",    256'(m_valid), 256'(0));
        tick();
        check("mr_out_valid", 256'(m_valid), 256'(1));
        check("mr_out_tag",   256'(m_tag),   256'(6'h04));
        check("mr_out_q",     256'(m_queue), 256'(13'h301));
        s_valid = 2'b00;
        tick();
        check("mr_drain", 256'(m_valid), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
